// File: rtl/mac_pe_v2.sv
// Output-stationary systolic PE: signed multiply or clamped shift-multiply into a wide
// accumulator, with a result drain chain. Define MAC_SAT_EN for saturating accumulation and ovf.
module mac_pe_v2 #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int SHIFT_MAX = 8,
  parameter int DRAIN_LEN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [DATA_W-1:0] up_in,
  input  logic              up_valid_in,
  input  logic [DATA_W-1:0] left_in,
  input  logic              left_valid_in,
  output logic [DATA_W-1:0] up_out,
  output logic              up_valid_out,
  output logic [DATA_W-1:0] left_out,
  output logic              left_valid_out,
  input  logic              acc_clr,
  input  logic              drain_start,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_valid_in,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_valid_out,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic {S_ACC, S_DRAIN} state_t;

  localparam logic [DATA_W-1:0] SH_LIM    = DATA_W'(SHIFT_MAX);
  localparam logic [7:0]        DRAIN_CNT = 8'(DRAIN_LEN);

  state_t              state_reg, state_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [ACC_W-1:0]    res_reg, res_next;
  logic                res_valid_reg, res_valid_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [DATA_W-1:0]   up_reg, left_reg;
  logic                up_valid_reg, left_valid_reg;

  logic                fire, drain_go;
  logic [DATA_W-1:0]   sh;
  logic signed [DATA_W-1:0]   left_s;
  logic signed [2*DATA_W-1:0] mul_full;
  logic signed [ACC_W-1:0]    left_ext, mul_ext;
  logic [ACC_W-1:0]    shl, prod, base, acc_sum;

  assign fire     = up_valid_in & left_valid_in;
  assign drain_go = (state_reg == S_ACC) & drain_start;

  // Operands are sign-extended to the accumulator width before use.
  assign left_s   = left_in;
  assign mul_full = $signed(up_in) * $signed(left_in);
  assign mul_ext  = ACC_W'(mul_full);
  assign left_ext = ACC_W'(left_s);
  assign sh       = (up_in > SH_LIM) ? SH_LIM : up_in;
  assign shl      = left_ext <<< sh;

  always_comb begin
    prod = '0;
    if (fire) prod = mode ? shl : mul_ext;
  end

  assign base = acc_clr ? '0 : acc_reg;

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           clamp;
  logic           ovf_reg, ovf_next;

  // One guard bit: differing top two bits means the signed add left the range.
  assign sum_wide = {base[ACC_W-1], base} + {prod[ACC_W-1], prod};
  assign clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign acc_sum  = !clamp ? sum_wide[ACC_W-1:0] : (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX);

  always_comb begin
    ovf_next = ovf_reg | clamp;
    if (drain_go)     ovf_next = 1'b0;
    else if (acc_clr) ovf_next = clamp;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_reg <= 1'b0;
    else       ovf_reg <= ovf_next;
  end

  assign ovf = ovf_reg;
`else
  assign acc_sum = base + prod;
  assign ovf     = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_sum;
    res_next       = res_reg;
    res_valid_next = 1'b0;
    cnt_next       = cnt_reg;
    case (state_reg)
      S_ACC: begin
        if (drain_go) begin
          res_next       = acc_sum;
          res_valid_next = 1'b1;
          acc_next       = '0;
          cnt_next       = DRAIN_CNT;
          if (DRAIN_LEN > 0) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_next       = res_in;
        res_valid_next = res_valid_in;
        cnt_next       = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = S_ACC;
      end
      default: state_next = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_ACC;
      acc_reg        <= '0;
      res_reg        <= '0;
      res_valid_reg  <= 1'b0;
      cnt_reg        <= '0;
      up_reg         <= '0;
      left_reg       <= '0;
      up_valid_reg   <= 1'b0;
      left_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      res_reg        <= res_next;
      res_valid_reg  <= res_valid_next;
      cnt_reg        <= cnt_next;
      up_reg         <= up_in;
      left_reg       <= left_in;
      up_valid_reg   <= up_valid_in;
      left_valid_reg <= left_valid_in;
    end
  end

  assign up_out         = up_reg;
  assign up_valid_out   = up_valid_reg;
  assign left_out       = left_reg;
  assign left_valid_out = left_valid_reg;
  assign res_out        = res_reg;
  assign res_valid_out  = res_valid_reg;
  assign busy           = (state_reg == S_DRAIN);

endmodule
